// File: rtl/regfile_access_scheduler.sv
// Arbitrates the single-ported register file between decode reads and a buffered
// writeback queue, with read-after-write forwarding, starvation limiting and a flush FSM.
module regfile_access_scheduler #(
    parameter int unsigned ADDR_W       = 6,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned WQ_DEPTH     = 4,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_rd_req,
    input  logic [ADDR_W-1:0]             i_rd_rs,
    input  logic [ADDR_W-1:0]             i_rd_rt,
    output logic                          o_rd_gnt,
    output logic                          o_rd_valid,
    output logic [DATA_W-1:0]             o_rd_xrs,
    output logic [DATA_W-1:0]             o_rd_xrt,
    input  logic                          i_wr_valid,
    output logic                          o_wr_ready,
    input  logic [ADDR_W-1:0]             i_wr_addr,
    input  logic [DATA_W-1:0]             i_wr_data,
    input  logic                          i_flush_req,
    output logic                          o_flush_done,
    output logic [$clog2(WQ_DEPTH):0]     o_wq_count,
    output logic [ADDR_W-1:0]             o_rf_rs,
    output logic [ADDR_W-1:0]             o_rf_rt,
    output logic [ADDR_W-1:0]             o_rf_rd,
    output logic [DATA_W-1:0]             o_rf_data_in,
    output logic                          o_rf_write,
    input  logic [DATA_W-1:0]             i_rf_xrs,
    input  logic [DATA_W-1:0]             i_rf_xrt
);

    localparam int unsigned PTR_W = $clog2(WQ_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [0:0] {
        StRun,
        StDrain
    } state_e;

    logic [ADDR_W-1:0] r_wq_addr [WQ_DEPTH];
    logic [DATA_W-1:0] r_wq_data [WQ_DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_count_nxt;
    logic [STV_W-1:0]  r_starve;
    logic [STV_W-1:0]  w_starve_nxt;
    state_e            r_state;
    state_e            w_state_nxt;
    logic              r_flush_done;
    logic              w_flush_done_nxt;

    logic              w_empty;
    logic              w_full;
    logic              w_push;
    logic              w_wr_gnt;
    logic              w_rd_gnt;

    logic              w_hit_rs;
    logic              w_hit_rt;
    logic [DATA_W-1:0] w_fwd_rs;
    logic [DATA_W-1:0] w_fwd_rt;

    logic              r_rd_valid;
    logic              r_hit_rs;
    logic              r_hit_rt;
    logic [DATA_W-1:0] r_fwd_rs;
    logic [DATA_W-1:0] r_fwd_rt;
    logic [DATA_W-1:0] r_xrs_last;
    logic [DATA_W-1:0] r_xrt_last;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(WQ_DEPTH));
    // A full queue refuses a push even when the head pops on the same edge.
    assign w_push  = i_wr_valid && !w_full;

    always_comb begin
        w_wr_gnt = 1'b0;
        w_rd_gnt = 1'b0;
        if (i_rst_n) begin
            if (r_state == StDrain) begin
                w_wr_gnt = !w_empty;
            end else begin
                w_wr_gnt = !w_empty &&
                           (!i_rd_req || w_full || (r_starve == STV_W'(STARVE_LIMIT)));
                w_rd_gnt = !w_wr_gnt && i_rd_req;
            end
        end
    end

    always_comb begin
        w_count_nxt = r_count;
        unique case ({w_push, w_wr_gnt})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_comb begin
        w_starve_nxt = r_starve;
        if (w_wr_gnt || (w_count_nxt == '0)) begin
            w_starve_nxt = '0;
        end else if (w_rd_gnt) begin
            w_starve_nxt = w_empty ? '0 : r_starve + STV_W'(1);
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_flush_done_nxt = 1'b0;
        unique case (r_state)
            StRun: begin
                if (i_flush_req) begin
                    if (w_count_nxt == '0) begin
                        w_flush_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = StDrain;
                    end
                end
            end
            StDrain: begin
                if (w_count_nxt == '0) begin
                    w_state_nxt      = StRun;
                    w_flush_done_nxt = 1'b1;
                end
            end
            default: w_state_nxt = StRun;
        endcase
    end

    // Walk oldest to youngest so the last match is the most recent write.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx      = '0;
        w_hit_rs = 1'b0;
        w_hit_rt = 1'b0;
        w_fwd_rs = '0;
        w_fwd_rt = '0;
        for (int i = 0; i < int'(WQ_DEPTH); i++) begin
            idx = r_head + PTR_W'(i);
            if (CNT_W'(i) < r_count) begin
                if (r_wq_addr[idx] == i_rd_rs) begin
                    w_hit_rs = 1'b1;
                    w_fwd_rs = r_wq_data[idx];
                end
                if (r_wq_addr[idx] == i_rd_rt) begin
                    w_hit_rt = 1'b1;
                    w_fwd_rt = r_wq_data[idx];
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_starve     <= '0;
            r_state      <= StRun;
            r_flush_done <= 1'b0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_wr_gnt) begin
                r_head <= r_head + PTR_W'(1);
            end
            r_count      <= w_count_nxt;
            r_starve     <= w_starve_nxt;
            r_state      <= w_state_nxt;
            r_flush_done <= w_flush_done_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_wq_addr[r_tail] <= i_wr_addr;
            r_wq_data[r_tail] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_valid <= 1'b0;
            r_hit_rs   <= 1'b0;
            r_hit_rt   <= 1'b0;
            r_fwd_rs   <= '0;
            r_fwd_rt   <= '0;
            r_xrs_last <= '0;
            r_xrt_last <= '0;
        end else begin
            r_rd_valid <= w_rd_gnt;
            if (w_rd_gnt) begin
                r_hit_rs <= w_hit_rs;
                r_hit_rt <= w_hit_rt;
                r_fwd_rs <= w_fwd_rs;
                r_fwd_rt <= w_fwd_rt;
            end
            if (r_rd_valid) begin
                r_xrs_last <= o_rd_xrs;
                r_xrt_last <= o_rd_xrt;
            end
        end
    end

    // Register-file data arrives the cycle after the grant, so the mux sits after the flops.
    assign o_rd_xrs = r_rd_valid ? (r_hit_rs ? r_fwd_rs : i_rf_xrs) : r_xrs_last;
    assign o_rd_xrt = r_rd_valid ? (r_hit_rt ? r_fwd_rt : i_rf_xrt) : r_xrt_last;

    assign o_rd_gnt     = w_rd_gnt;
    assign o_rd_valid   = r_rd_valid;
    assign o_wr_ready   = !w_full;
    assign o_flush_done = r_flush_done;
    assign o_wq_count   = r_count;
    assign o_rf_rs      = i_rd_rs;
    assign o_rf_rt      = i_rd_rt;
    assign o_rf_rd      = r_wq_addr[r_head];
    assign o_rf_data_in = r_wq_data[r_head];
    assign o_rf_write   = w_wr_gnt;

endmodule

// File: tb/tb_regfile_access_scheduler.sv
// Directed bench for regfile_access_scheduler with a behavioural 64x32 register file
// (read pair or one write per edge) attached to the rf_* ports.
module tb_regfile_access_scheduler;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_rd_req;
    logic [5:0]  i_rd_rs;
    logic [5:0]  i_rd_rt;
    logic        o_rd_gnt;
    logic        o_rd_valid;
    logic [31:0] o_rd_xrs;
    logic [31:0] o_rd_xrt;
    logic        i_wr_valid;
    logic        o_wr_ready;
    logic [5:0]  i_wr_addr;
    logic [31:0] i_wr_data;
    logic        i_flush_req;
    logic        o_flush_done;
    logic [2:0]  o_wq_count;
    logic [5:0]  o_rf_rs;
    logic [5:0]  o_rf_rt;
    logic [5:0]  o_rf_rd;
    logic [31:0] o_rf_data_in;
    logic        o_rf_write;
    logic [31:0] i_rf_xrs;
    logic [31:0] i_rf_xrt;

    logic [31:0] rf_mem [64];
    int          n_checks;
    int          n_fail;

    regfile_access_scheduler #(
        .ADDR_W       (6),
        .DATA_W       (32),
        .WQ_DEPTH     (4),
        .STARVE_LIMIT (3)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_rd_req     (i_rd_req),
        .i_rd_rs      (i_rd_rs),
        .i_rd_rt      (i_rd_rt),
        .o_rd_gnt     (o_rd_gnt),
        .o_rd_valid   (o_rd_valid),
        .o_rd_xrs     (o_rd_xrs),
        .o_rd_xrt     (o_rd_xrt),
        .i_wr_valid   (i_wr_valid),
        .o_wr_ready   (o_wr_ready),
        .i_wr_addr    (i_wr_addr),
        .i_wr_data    (i_wr_data),
        .i_flush_req  (i_flush_req),
        .o_flush_done (o_flush_done),
        .o_wq_count   (o_wq_count),
        .o_rf_rs      (o_rf_rs),
        .o_rf_rt      (o_rf_rt),
        .o_rf_rd      (o_rf_rd),
        .o_rf_data_in (o_rf_data_in),
        .o_rf_write   (o_rf_write),
        .i_rf_xrs     (i_rf_xrs),
        .i_rf_xrt     (i_rf_xrt)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Register file: preset r[i] = 0x1000_0000 | i so forwarded and stored data differ.
    initial begin
        for (int i = 0; i < 64; i++) rf_mem[i] = 32'h1000_0000 | i;
    end

    always @(posedge i_clk) begin
        if (o_rf_write) begin
            rf_mem[o_rf_rd] = o_rf_data_in;
        end else begin
            i_rf_xrs <= rf_mem[o_rf_rs];
            i_rf_xrt <= rf_mem[o_rf_rt];
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic [5:0] rs, input logic [5:0] rt,
                         input logic wv, input logic [5:0] wa, input logic [31:0] wd);
        i_rd_req   = rd;
        i_rd_rs    = rs;
        i_rd_rt    = rt;
        i_wr_valid = wv;
        i_wr_addr  = wa;
        i_wr_data  = wd;
        #1;
    endtask

    task automatic test_reset();
        i_rst_n     = 1'b0;
        i_flush_req = 1'b0;
        drive(1'b1, 6'd1, 6'd2, 1'b1, 6'd9, 32'h9);
        repeat (2) @(posedge i_clk);
        #1;
        n_checks++; if (o_rd_gnt !== 1'b0) begin n_fail++;
            $display("FAIL reset_rd_gnt: got %b want 0", o_rd_gnt); end
        n_checks++; if (o_rf_write !== 1'b0) begin n_fail++;
            $display("FAIL reset_rf_write: got %b want 0", o_rf_write); end
        n_checks++; if (o_wq_count !== 3'd0) begin n_fail++;
            $display("FAIL reset_wq_count: got %0d want 0", o_wq_count); end
        n_checks++; if (o_rd_valid !== 1'b0) begin n_fail++;
            $display("FAIL reset_rd_valid: got %b want 0", o_rd_valid); end
        n_checks++; if (o_rd_xrs !== 32'h0 || o_rd_xrt !== 32'h0) begin n_fail++;
            $display("FAIL reset_rd_data: got %h/%h want 0/0", o_rd_xrs, o_rd_xrt); end
        n_checks++; if (o_flush_done !== 1'b0 || o_wr_ready !== 1'b1) begin n_fail++;
            $display("FAIL reset_flags: got done=%b ready=%b want 0/1", o_flush_done, o_wr_ready); end
        drive(1'b0, 6'd0, 6'd0, 1'b0, 6'd0, 32'h0);
        i_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_write_drain();
        drive(1'b0, 6'd0, 6'd0, 1'b1, 6'd5, 32'hDEAD_BEEF);
        n_checks++; if (o_rf_write !== 1'b0 || o_wr_ready !== 1'b1) begin n_fail++;
            $display("FAIL wd_idle: got write=%b ready=%b want 0/1", o_rf_write, o_wr_ready); end
        tick();
        drive(1'b0, 6'd0, 6'd0, 1'b0, 6'd0, 32'h0);
        n_checks++; if (o_wq_count !== 3'd1) begin n_fail++;
            $display("FAIL wd_count1: got %0d want 1", o_wq_count); end
        n_checks++; if (o_rf_write !== 1'b1 || o_rf_rd !== 6'd5 || o_rf_data_in !== 32'hDEAD_BEEF)
            begin n_fail++; $display("FAIL wd_grant: got w=%b rd=%0d d=%h want 1/5/deadbeef",
                o_rf_write, o_rf_rd, o_rf_data_in); end
        tick();
        n_checks++; if (o_wq_count !== 3'd0 || o_rf_write !== 1'b0) begin n_fail++;
            $display("FAIL wd_count0: got cnt=%0d w=%b want 0/0", o_wq_count, o_rf_write); end
        n_checks++; if (rf_mem[5] !== 32'hDEAD_BEEF) begin n_fail++;
            $display("FAIL wd_rf5: got %h want deadbeef", rf_mem[5]); end
    endtask

    task automatic test_forward();
        drive(1'b0, 6'd0, 6'd0, 1'b1, 6'd7, 32'h11);
        tick();
        drive(1'b1, 6'd7, 6'd2, 1'b0, 6'd0, 32'h0);
        n_checks++; if (o_rd_gnt !== 1'b1 || o_rf_write !== 1'b0) begin n_fail++;
            $display("FAIL fw_gnt: got gnt=%b w=%b want 1/0", o_rd_gnt, o_rf_write); end
        tick();
        drive(1'b0, 6'd0, 6'd0, 1'b0, 6'd0, 32'h0);
        n_checks++; if (o_rd_valid !== 1'b1 || o_rd_xrs !== 32'h11 || o_rd_xrt !== 32'h1000_0002)
            begin n_fail++; $display("FAIL fw_data: got v=%b %h/%h want 1 00000011/10000002",
                o_rd_valid, o_rd_xrs, o_rd_xrt); end
        n_checks++; if (o_rf_write !== 1'b1 || o_rf_rd !== 6'd7) begin n_fail++;
            $display("FAIL fw_drain: got w=%b rd=%0d want 1/7", o_rf_write, o_rf_rd); end
        tick();
        n_checks++; if (o_rd_valid !== 1'b0 || o_rd_xrs !== 32'h11 || o_wq_count !== 3'd0)
            begin n_fail++; $display("FAIL fw_hold: got v=%b xrs=%h cnt=%0d want 0/00000011/0",
                o_rd_valid, o_rd_xrs, o_wq_count); end
    endtask

    task automatic test_youngest();
        drive(1'b0, 6'd0, 6'd0, 1'b1, 6'd3, 32'hA);
        tick();
        drive(1'b1, 6'd9, 6'd9, 1'b1, 6'd3, 32'hB);
        tick();
        drive(1'b1, 6'd3, 6'd3, 1'b0, 6'd0, 32'h0);
        n_checks++; if (o_wq_count !== 3'd2 || o_rd_gnt !== 1'b1) begin n_fail++;
            $display("FAIL yg_setup: got cnt=%0d gnt=%b want 2/1", o_wq_count, o_rd_gnt); end
        n_checks++; if (o_rd_valid !== 1'b1 || o_rd_xrs !== 32'h1000_0009) begin n_fail++;
            $display("FAIL yg_rf9: got v=%b %h want 1/10000009", o_rd_valid, o_rd_xrs); end
        tick();
        drive(1'b0, 6'd0, 6'd0, 1'b0, 6'd0, 32'h0);
        n_checks++; if (o_rd_xrs !== 32'hB || o_rd_xrt !== 32'hB) begin n_fail++;
            $display("FAIL yg_fwd: got %h/%h want 0000000b/0000000b", o_rd_xrs, o_rd_xrt); end
        n_checks++; if (o_rf_write !== 1'b1 || o_rf_data_in !== 32'hA) begin n_fail++;
            $display("FAIL yg_pop1: got w=%b d=%h want 1/0000000a", o_rf_write, o_rf_data_in); end
        tick();
        n_checks++; if (o_rf_write !== 1'b1 || o_rf_data_in !== 32'hB) begin n_fail++;
            $display("FAIL yg_pop2: got w=%b d=%h want 1/0000000b", o_rf_write, o_rf_data_in); end
        tick();
        drive(1'b1, 6'd3, 6'd5, 1'b0, 6'd0, 32'h0);
        tick();
        drive(1'b0, 6'd0, 6'd0, 1'b0, 6'd0, 32'h0);
        n_checks++; if (o_rd_xrs !== 32'hB || o_rd_xrt !== 32'hDEAD_BEEF) begin n_fail++;
            $display("FAIL yg_rfread: got %h/%h want 0000000b/deadbeef", o_rd_xrs, o_rd_xrt); end
        tick();
    endtask

    task automatic test_starvation();
        logic [4:0] exp_gnt;
        logic [4:0] exp_wr;
        exp_gnt = 5'b10111;
        exp_wr  = 5'b01000;
        drive(1'b0, 6'd0, 6'd0, 1'b1, 6'd10, 32'h55);
        tick();
        drive(1'b1, 6'd1, 6'd2, 1'b0, 6'd0, 32'h0);
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if (o_rd_gnt !== exp_gnt[c] || o_rf_write !== exp_wr[c]) begin
                n_fail++;
                $display("FAIL starve_cycle%0d: got gnt=%b w=%b want %b/%b",
                         c, o_rd_gnt, o_rf_write, exp_gnt[c], exp_wr[c]);
            end
            tick();
        end
        drive(1'b0, 6'd0, 6'd0, 1'b0, 6'd0, 32'h0);
        tick();
    endtask

    task automatic test_full();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 6'd20, 6'd21, 1'b1, 6'(20 + k), 32'hC0 + k);
            n_checks++; if (o_rd_gnt !== 1'b1 || o_wr_ready !== 1'b1) begin n_fail++;
                $display("FAIL full_fill%0d: got gnt=%b ready=%b want 1/1", k, o_rd_gnt, o_wr_ready); end
            if (k == 1) begin
                n_checks++; if (o_rd_xrs !== 32'h1000_0014 || o_rd_xrt !== 32'h1000_0015) begin
                    n_fail++; $display("FAIL full_nofwd_same_edge: got %h/%h want 10000014/10000015",
                        o_rd_xrs, o_rd_xrt); end
            end
            if (k == 2) begin
                n_checks++; if (o_rd_xrs !== 32'hC0 || o_rd_xrt !== 32'h1000_0015) begin
                    n_fail++; $display("FAIL full_fwd_partial: got %h/%h want 000000c0/10000015",
                        o_rd_xrs, o_rd_xrt); end
            end
            tick();
        end
        drive(1'b1, 6'd20, 6'd21, 1'b1, 6'd24, 32'hBAD);
        n_checks++; if (o_wr_ready !== 1'b0 || o_wq_count !== 3'd4) begin n_fail++;
            $display("FAIL full_ready: got ready=%b cnt=%0d want 0/4", o_wr_ready, o_wq_count); end
        n_checks++; if (o_rd_gnt !== 1'b0 || o_rf_write !== 1'b1 || o_rf_rd !== 6'd20) begin
            n_fail++; $display("FAIL full_forced_wr: got gnt=%b w=%b rd=%0d want 0/1/20",
                o_rd_gnt, o_rf_write, o_rf_rd); end
        tick();
        drive(1'b0, 6'd0, 6'd0, 1'b1, 6'd25, 32'hC5);
        n_checks++; if (o_wr_ready !== 1'b1 || o_wq_count !== 3'd3) begin n_fail++;
            $display("FAIL full_after: got ready=%b cnt=%0d want 1/3", o_wr_ready, o_wq_count); end
        tick();
        drive(1'b0, 6'd0, 6'd0, 1'b0, 6'd0, 32'h0);
        n_checks++; if (o_wq_count !== 3'd3) begin n_fail++;
            $display("FAIL full_pushpop: got cnt=%0d want 3", o_wq_count); end
        repeat (3) tick();
        n_checks++; if (o_wq_count !== 3'd0 || rf_mem[23] !== 32'hC3 || rf_mem[25] !== 32'hC5)
            begin n_fail++; $display("FAIL full_drained: got cnt=%0d r23=%h r25=%h want 0/c3/c5",
                o_wq_count, rf_mem[23], rf_mem[25]); end
        n_checks++; if (rf_mem[24] !== 32'h1000_0018) begin n_fail++;
            $display("FAIL full_rejected: got r24=%h want 10000018", rf_mem[24]); end
    endtask

    task automatic test_flush();
        drive(1'b1, 6'd1, 6'd2, 1'b1, 6'd30, 32'h30);
        tick();
        drive(1'b1, 6'd1, 6'd2, 1'b1, 6'd31, 32'h31);
        tick();
        i_flush_req = 1'b1;
        drive(1'b1, 6'd1, 6'd2, 1'b0, 6'd0, 32'h0);
        n_checks++; if (o_rd_gnt !== 1'b1 || o_wq_count !== 3'd2) begin n_fail++;
            $display("FAIL fl_run: got gnt=%b cnt=%0d want 1/2", o_rd_gnt, o_wq_count); end
        tick();
        i_flush_req = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_checks++; if (o_rd_gnt !== 1'b0 || o_rf_write !== 1'b1 || o_flush_done !== 1'b0)
                begin n_fail++; $display("FAIL fl_drain%0d: got gnt=%b w=%b done=%b want 0/1/0",
                    c, o_rd_gnt, o_rf_write, o_flush_done); end
            tick();
        end
        #1;
        n_checks++; if (o_flush_done !== 1'b1 || o_rd_gnt !== 1'b1) begin n_fail++;
            $display("FAIL fl_done: got done=%b gnt=%b want 1/1", o_flush_done, o_rd_gnt); end
        tick();
        drive(1'b0, 6'd0, 6'd0, 1'b0, 6'd0, 32'h0);
        n_checks++; if (o_flush_done !== 1'b0 || rf_mem[31] !== 32'h31) begin n_fail++;
            $display("FAIL fl_pulse: got done=%b r31=%h want 0/31", o_flush_done, rf_mem[31]); end
        i_flush_req = 1'b1;
        tick();
        i_flush_req = 1'b0;
        #1;
        n_checks++; if (o_flush_done !== 1'b1) begin n_fail++;
            $display("FAIL fl_empty: got done=%b want 1", o_flush_done); end
        tick();
        n_checks++; if (o_flush_done !== 1'b0) begin n_fail++;
            $display("FAIL fl_empty_pulse: got done=%b want 0", o_flush_done); end
    endtask

    task automatic test_reset_mid_drain();
        drive(1'b1, 6'd1, 6'd2, 1'b1, 6'd40, 32'h40);
        tick();
        drive(1'b1, 6'd1, 6'd2, 1'b1, 6'd41, 32'h41);
        tick();
        i_flush_req = 1'b1;
        drive(1'b1, 6'd1, 6'd2, 1'b0, 6'd0, 32'h0);
        tick();
        i_flush_req = 1'b0;
        #1;
        n_checks++; if (o_rf_write !== 1'b1 || o_wq_count !== 3'd2) begin n_fail++;
            $display("FAIL rm_draining: got w=%b cnt=%0d want 1/2", o_rf_write, o_wq_count); end
        i_rst_n = 1'b0;
        #1;
        n_checks++; if (o_wq_count !== 3'd0 || o_rf_write !== 1'b0 || o_rd_gnt !== 1'b0)
            begin n_fail++; $display("FAIL rm_async: got cnt=%0d w=%b gnt=%b want 0/0/0",
                o_wq_count, o_rf_write, o_rd_gnt); end
        tick();
        i_rst_n = 1'b1;
        drive(1'b0, 6'd0, 6'd0, 1'b0, 6'd0, 32'h0);
        n_checks++; if (o_wq_count !== 3'd0 || o_rf_write !== 1'b0) begin n_fail++;
            $display("FAIL rm_discard: got cnt=%0d w=%b want 0/0", o_wq_count, o_rf_write); end
        tick();
        n_checks++; if (rf_mem[40] !== 32'h1000_0028 || o_flush_done !== 1'b0) begin n_fail++;
            $display("FAIL rm_nowrite: got r40=%h done=%b want 10000028/0", rf_mem[40], o_flush_done); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_write_drain();
        test_forward();
        test_youngest();
        test_starvation();
        test_full();
        test_flush();
        test_reset_mid_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
